morse_char_encoder: RTL and testbench

//  Upstream stage of the Morse transmit FSM. Accepts one character code per valid/ready handshake.

---
 rtl/morse_pkg.sv | 69 ++++++
 rtl/morse_rom.sv | 22 ++
 rtl/morse_char_encoder.sv | 148 ++++++++++++++
 tb/tb_morse_char_encoder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse definitions: character codes, default timing gaps, FSM states and
// the ITU symbol table (len symbols, pattern LSB first, 0 = dot, 1 = dash).
package morse_pkg;

   localparam int CODE_WORD_SPACE = 36;
   localparam int CODE_MAX_VALID  = 36;

   localparam int DEF_SYM_GAP  = 2;
   localparam int DEF_CHAR_GAP = 4;
   localparam int DEF_WORD_GAP = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYM,
      ST_SYM_GAP,
      ST_CSPACE,
      ST_CGAP,
      ST_WSPACE,
      ST_WGAP
   } morse_state_t;

   typedef struct packed {
      logic [2:0] len;
      logic [4:0] pat;
   } morse_sym_t;

   function automatic morse_sym_t sym_lookup(input logic [5:0] idx);
      case (idx)
         6'd0:  sym_lookup = {3'd2, 5'b00010};  // A .-
         6'd1:  sym_lookup = {3'd4, 5'b00001};  // B -...
         6'd2:  sym_lookup = {3'd4, 5'b00101};  // C -.-.
         6'd3:  sym_lookup = {3'd3, 5'b00001};  // D -..
         6'd4:  sym_lookup = {3'd1, 5'b00000};  // E .
         6'd5:  sym_lookup = {3'd4, 5'b00100};  // F ..-.
         6'd6:  sym_lookup = {3'd3, 5'b00011};  // G --.
         6'd7:  sym_lookup = {3'd4, 5'b00000};  // H ....
         6'd8:  sym_lookup = {3'd2, 5'b00000};  // I ..
         6'd9:  sym_lookup = {3'd4, 5'b01110};  // J .---
         6'd10: sym_lookup = {3'd3, 5'b00101};  // K -.-
         6'd11: sym_lookup = {3'd4, 5'b00010};  // L .-..
         6'd12: sym_lookup = {3'd2, 5'b00011};  // M --
         6'd13: sym_lookup = {3'd2, 5'b00001};  // N -.
         6'd14: sym_lookup = {3'd3, 5'b00111};  // O ---
         6'd15: sym_lookup = {3'd4, 5'b00110};  // P .--.
         6'd16: sym_lookup = {3'd4, 5'b01011};  // Q --.-
         6'd17: sym_lookup = {3'd3, 5'b00010};  // R .-.
         6'd18: sym_lookup = {3'd3, 5'b00000};  // S ...
         6'd19: sym_lookup = {3'd1, 5'b00001};  // T -
         6'd20: sym_lookup = {3'd3, 5'b00100};  // U ..-
         6'd21: sym_lookup = {3'd4, 5'b01000};  // V ...-
         6'd22: sym_lookup = {3'd3, 5'b00110};  // W .--
         6'd23: sym_lookup = {3'd4, 5'b01001};  // X -..-
         6'd24: sym_lookup = {3'd4, 5'b01101};  // Y -.--
         6'd25: sym_lookup = {3'd4, 5'b00011};  // Z --..
         6'd26: sym_lookup = {3'd5, 5'b11111};  // 0 -----
         6'd27: sym_lookup = {3'd5, 5'b11110};  // 1 .----
         6'd28: sym_lookup = {3'd5, 5'b11100};  // 2 ..---
         6'd29: sym_lookup = {3'd5, 5'b11000};  // 3 ...--
         6'd30: sym_lookup = {3'd5, 5'b10000};  // 4 ....-
         6'd31: sym_lookup = {3'd5, 5'b00000};  // 5 .....
         6'd32: sym_lookup = {3'd5, 5'b00001};  // 6 -....
         6'd33: sym_lookup = {3'd5, 5'b00011};  // 7 --...
         6'd34: sym_lookup = {3'd5, 5'b00111};  // 8 ---..
         6'd35: sym_lookup = {3'd5, 5'b01111};  // 9 ----.
         default: sym_lookup = {3'd0, 5'b00000};
      endcase
   endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character-code lookup; word space is valid but carries no symbols.
module morse_rom
   import morse_pkg::*;
#(
   parameter int CODE_W = 6
) (
   input  logic [CODE_W-1:0] code,
   output logic              valid,
   output logic [2:0]        len,
   output logic [4:0]        pat
);

   morse_sym_t ent;

   always_comb begin
      valid = (code <= CODE_W'(CODE_MAX_VALID));
      ent   = sym_lookup(6'(code));
      len   = ent.len;
      pat   = ent.pat;
   end

endmodule

// File: rtl/morse_char_encoder.sv
// Character-to-pulse encoder: one char per handshake, registered one-cycle
// dot/dash/space/error requests spaced for the downstream transmit FSM.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ST_IDLE    | ready for a character
//   ST_SYM     | dot or dash pulse is on the output
//   ST_SYM_GAP | inter-symbol spacing, SYM_GAP-1 cycles
//   ST_CSPACE  | char-space pulse is on the output
//   ST_CGAP    | post-character spacing, CHAR_GAP-1 cycles
//   ST_WSPACE  | word-space pulse is on the output
//   ST_WGAP    | post-word spacing, WORD_GAP-1 cycles
module morse_char_encoder
   import morse_pkg::*;
#(
   parameter int CODE_W   = 6,
   parameter int SYM_GAP  = DEF_SYM_GAP,
   parameter int CHAR_GAP = DEF_CHAR_GAP,
   parameter int WORD_GAP = DEF_WORD_GAP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              char_valid,
   input  logic [CODE_W-1:0] char_code,
   output logic              char_ready,
   output logic              dot_out,
   output logic              dash_out,
   output logic              char_space_out,
   output logic              word_space_out,
   output logic              err_out,
   output logic              busy
);

   localparam int CNT_W = $clog2(WORD_GAP + 1);

   morse_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       pat_q, pat_d;
   logic [2:0]       left_q, left_d;
   logic             dot_d, dash_d, csp_d, wsp_d, err_d;
   logic             rom_valid;
   logic [2:0]       rom_len;
   logic [4:0]       rom_pat;
   logic             take;

   morse_rom #(.CODE_W(CODE_W)) u_rom (
      .code  (char_code),
      .valid (rom_valid),
      .len   (rom_len),
      .pat   (rom_pat)
   );

   assign char_ready = (state_q == ST_IDLE) && !rst;
   assign busy       = (state_q != ST_IDLE);
   assign take       = char_valid && char_ready;

   // Pulses are computed from the transition into a state so that each
   // registered pulse lines up with the cycle spent in that state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      left_d  = left_q;
      dot_d   = 1'b0;
      dash_d  = 1'b0;
      csp_d   = 1'b0;
      wsp_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               if (!rom_valid) begin
                  err_d = 1'b1;
               end else if (char_code == CODE_W'(CODE_WORD_SPACE)) begin
                  state_d = ST_WSPACE;
                  wsp_d   = 1'b1;
               end else begin
                  state_d = ST_SYM;
                  pat_d   = rom_pat;
                  left_d  = rom_len;
                  dot_d   = !rom_pat[0];
                  dash_d  = rom_pat[0];
               end
            end
         end
         ST_SYM: begin
            pat_d   = pat_q >> 1;
            left_d  = left_q - 3'd1;
            cnt_d   = CNT_W'(SYM_GAP - 2);
            state_d = ST_SYM_GAP;
         end
         ST_SYM_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (left_q != 3'd0) begin
               state_d = ST_SYM;
               dot_d   = !pat_q[0];
               dash_d  = pat_q[0];
            end else begin
               state_d = ST_CSPACE;
               csp_d   = 1'b1;
            end
         end
         ST_CSPACE: begin
            cnt_d   = CNT_W'(CHAR_GAP - 2);
            state_d = ST_CGAP;
         end
         ST_CGAP: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else             state_d = ST_IDLE;
         end
         ST_WSPACE: begin
            cnt_d   = CNT_W'(WORD_GAP - 2);
            state_d = ST_WGAP;
         end
         ST_WGAP: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else             state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         pat_q          <= '0;
         left_q         <= '0;
         dot_out        <= 1'b0;
         dash_out       <= 1'b0;
         char_space_out <= 1'b0;
         word_space_out <= 1'b0;
         err_out        <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         pat_q          <= pat_d;
         left_q         <= left_d;
         dot_out        <= dot_d;
         dash_out       <= dash_d;
         char_space_out <= csp_d;
         word_space_out <= wsp_d;
         err_out        <= err_d;
      end
   end

endmodule

// File: tb/tb_morse_char_encoder.sv
// Directed bench for morse_char_encoder: per-character pulse timelines from a
// vector table, plus back-to-back and mid-character reset sequences.
module tb_morse_char_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       char_valid;
   logic [5:0] char_code;
   logic       char_ready, dot_out, dash_out, char_space_out, word_space_out, err_out, busy;

   int checks = 0;
   int errors = 0;

   morse_char_encoder dut (
      .clk            (clk),
      .rst            (rst),
      .char_valid     (char_valid),
      .char_code      (char_code),
      .char_ready     (char_ready),
      .dot_out        (dot_out),
      .dash_out       (dash_out),
      .char_space_out (char_space_out),
      .word_space_out (word_space_out),
      .err_out        (err_out),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // Bit k of each mask = pulse expected in cycle k after the transfer edge.
   typedef struct packed {
      logic [5:0]  code;
      logic [16:0] dot;
      logic [16:0] dash;
      logic [16:0] csp;
      logic [16:0] wsp;
      logic [16:0] err;
      logic [4:0]  ready_at;
   } vec_t;

   vec_t vecs [11];

   function automatic logic [16:0] m(input int a, input int b = 0, input int c = 0,
                                     input int d = 0, input int e = 0);
      logic [16:0] r;
      r = '0;
      if (a > 0) r[a] = 1'b1;
      if (b > 0) r[b] = 1'b1;
      if (c > 0) r[c] = 1'b1;
      if (d > 0) r[d] = 1'b1;
      if (e > 0) r[e] = 1'b1;
      return r;
   endfunction

   task automatic check_cycle(input string tag, input int k, input logic [6:0] exp);
      logic [6:0] act;
      act = {dot_out, dash_out, char_space_out, word_space_out, err_out, char_ready, busy};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d {dot,dash,csp,wsp,err,ready,busy} got %b want %b",
                  tag, k, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d_code%0d", idx, v.code);
      @(negedge clk);
      check_cycle({tag, "_idle"}, 0, 7'b0000010);
      char_code  = v.code;
      char_valid = 1'b1;
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      char_code  = 6'd0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         check_cycle(tag, k, {v.dot[k], v.dash[k], v.csp[k], v.wsp[k], v.err[k],
                              k >= int'(v.ready_at), k < int'(v.ready_at)});
      end
   endtask

   // Request pulses must never overlap and never appear in adjacent cycles.
   logic prev_any = 1'b0;
   always @(negedge clk) begin
      int n;
      n = int'(dot_out) + int'(dash_out) + int'(char_space_out) + int'(word_space_out);
      if (n != 0) begin
         checks++;
         if (n > 1 || prev_any) begin
            errors++;
            $display("FAIL pulse_spacing at %0t: count %0d prev %0b, want count 1 prev 0",
                     $time, n, prev_any);
         end
      end
      prev_any = (n != 0);
   end

   initial begin
      vecs[0]  = '{code: 6'd4,  dot: m(1), dash: '0, csp: m(3), wsp: '0, err: '0, ready_at: 5'd7};
      vecs[1]  = '{code: 6'd0,  dot: m(1), dash: m(3), csp: m(5), wsp: '0, err: '0, ready_at: 5'd9};
      vecs[2]  = '{code: 6'd26, dot: '0, dash: m(1,3,5,7,9), csp: m(11), wsp: '0, err: '0, ready_at: 5'd15};
      vecs[3]  = '{code: 6'd36, dot: '0, dash: '0, csp: '0, wsp: m(1), err: '0, ready_at: 5'd9};
      vecs[4]  = '{code: 6'd40, dot: '0, dash: '0, csp: '0, wsp: '0, err: m(1), ready_at: 5'd1};
      vecs[5]  = '{code: 6'd19, dot: '0, dash: m(1), csp: m(3), wsp: '0, err: '0, ready_at: 5'd7};
      vecs[6]  = '{code: 6'd31, dot: m(1,3,5,7,9), dash: '0, csp: m(11), wsp: '0, err: '0, ready_at: 5'd15};
      vecs[7]  = '{code: 6'd16, dot: m(5), dash: m(1,3,7), csp: m(9), wsp: '0, err: '0, ready_at: 5'd13};
      vecs[8]  = '{code: 6'd35, dot: m(9), dash: m(1,3,5,7), csp: m(11), wsp: '0, err: '0, ready_at: 5'd15};
      vecs[9]  = '{code: 6'd37, dot: '0, dash: '0, csp: '0, wsp: '0, err: m(1), ready_at: 5'd1};
      vecs[10] = '{code: 6'd25, dot: m(5,7), dash: m(1,3), csp: m(9), wsp: '0, err: '0, ready_at: 5'd13};

      // Reset: outputs low and no transfer even with a valid character present.
      rst        = 1'b1;
      char_valid = 1'b1;
      char_code  = 6'd4;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_cycle("reset", k, 7'b0000000);
      end
      char_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_cycle("reset_release", 0, 7'b0000010);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // 'E' then 'T' held valid: T is taken on the first idle cycle.
      @(negedge clk);
      char_code  = 6'd4;
      char_valid = 1'b1;
      @(posedge clk);
      #1;
      char_code = 6'd19;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         check_cycle("e_then_t", k, {k == 1, k == 8, (k == 3) || (k == 10), 1'b0, 1'b0,
                                     (k == 7) || (k == 14), !((k == 7) || (k == 14))});
         if (k == 7) begin
            @(posedge clk);
            #1;
            char_valid = 1'b0;
         end
      end

      // 'A' interrupted by reset sampled at edge 4: no char-space afterwards.
      @(negedge clk);
      char_code  = 6'd0;
      char_valid = 1'b1;
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         check_cycle("rst_mid_char", k, {k == 1, k == 3, 1'b0, 1'b0, 1'b0,
                                         k >= 6, k <= 4});
         if (k == 3) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
         end
         if (k == 5) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
         end
      end
      run_vec(vecs[0], 99);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
